// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and defaults for the radix-2 Booth multiplier
package booth_pkg;

    localparam int BOOTH_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_addsub.sv
// rtl/booth_addsub.sv - adder/subtractor for the Booth accumulator, sub=1 gives a-b
module booth_addsub #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier; BOOTH_SIGNED_SEL_EN adds is_signed
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
`ifdef BOOTH_SIGNED_SEL_EN
    input  logic                 is_signed,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int AW = WIDTH + 2;

    state_t             state;
    logic [AW-1:0]      acc;
    logic [WIDTH:0]     q_reg;
    logic [WIDTH:0]     m_reg;
    logic               q_m1;
    logic [CW-1:0]      cnt;

    logic               mc_ext;
    logic               mp_ext;
    logic [AW-1:0]      sum;
    logic [AW-1:0]      step_a;

    // Extension bit is resolved at capture, so the mode never needs storing.
`ifdef BOOTH_SIGNED_SEL_EN
    assign mc_ext = is_signed & mcand[WIDTH-1];
    assign mp_ext = is_signed & mplier[WIDTH-1];
`else
    assign mc_ext = mcand[WIDTH-1];
    assign mp_ext = mplier[WIDTH-1];
`endif

    booth_addsub #(
        .W (AW)
    ) u_addsub (
        .a   (acc),
        .b   ({m_reg[WIDTH], m_reg}),
        .sub (q_reg[0]),
        .y   (sum)
    );

    assign step_a = (q_reg[0] ^ q_m1) ? sum : acc;
    assign busy   = (state == CALC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= {mc_ext, mcand};
                        q_reg <= {mp_ext, mplier};
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= CW'(WIDTH);
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Add/subtract and arithmetic shift of {A,Q,q-1} in one cycle.
                    acc   <= {step_a[AW-1], step_a[AW-1:1]};
                    q_reg <= {step_a[0], q_reg[WIDTH:1]};
                    q_m1  <= q_reg[0];
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    product <= {acc[WIDTH-2:0], q_reg};
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
